// File: rtl/mxint8_block_unpacker.sv
// Accepts one MXINT8 block (elements + shared E8M0 scale) and streams the elements
// out one per cycle as scaled, saturated signed fixed-point values (LSB = 2^-6).
`ifndef BLOCK_SIZE
`define BLOCK_SIZE 32
`endif

module mxint8_block_unpacker #(
   parameter int BLOCK_SIZE = `BLOCK_SIZE,
   parameter int OUT_WIDTH  = 16
) (
   input  logic                          i_clk,
   input  logic                          i_rst,
   input  logic                          i_block_valid,
   output logic                          o_block_ready,
   input  logic [7:0]                    i_mxint8_elements [0:BLOCK_SIZE-1],
   input  logic [7:0]                    i_shared_scale,
   input  logic                          i_treat_unused_encode_as_zero,
   output logic                          o_elem_valid,
   input  logic                          i_elem_ready,
   output logic [OUT_WIDTH-1:0]          o_elem_value,
   output logic [$clog2(BLOCK_SIZE)-1:0] o_elem_index,
   output logic                          o_elem_last,
   output logic                          o_elem_nan
);

   localparam int IDX_W  = $clog2(BLOCK_SIZE);
   localparam int WIDE_W = OUT_WIDTH + 9;

   localparam logic [0:0] IDLE   = 1'b0;
   localparam logic [0:0] STREAM = 1'b1;

   localparam logic [IDX_W-1:0] LAST_IDX = IDX_W'(BLOCK_SIZE - 1);
   localparam logic [7:0]       SH_SAT   = 8'(OUT_WIDTH);

   localparam logic signed [OUT_WIDTH-1:0] OUT_MAX = {1'b0, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [OUT_WIDTH-1:0] OUT_MIN = {1'b1, {(OUT_WIDTH-1){1'b0}}};
   localparam logic signed [WIDE_W-1:0] WIDE_MAX =
      {{(WIDE_W-OUT_WIDTH+1){1'b0}}, {(OUT_WIDTH-1){1'b1}}};
   localparam logic signed [WIDE_W-1:0] WIDE_MIN =
      {{(WIDE_W-OUT_WIDTH+1){1'b1}}, {(OUT_WIDTH-1){1'b0}}};

   logic [0:0]            r_state;
   logic [IDX_W-1:0]      r_index;
   logic [7:0]            r_elems [0:BLOCK_SIZE-1];
   logic [7:0]            r_scale;
   logic                  r_policy;
   logic                  r_block_ready;

   logic                  w_stream;
   logic [7:0]            w_cur;
   logic [OUT_WIDTH-1:0]  w_value;

   // Shifts with 2^(scale-127); large left shifts saturate before any wide shift is
   // attempted, so k up to 127 never overflows the intermediate.
   function automatic logic signed [OUT_WIDTH-1:0] decode_sat(
      input logic [7:0] e,
      input logic [7:0] scale,
      input logic       policy
   );
      logic signed [7:0]        ev;
      logic signed [7:0]        r8;
      logic signed [WIDE_W-1:0] wide;
      logic [7:0]               sh;
      decode_sat = {OUT_WIDTH{1'b0}};
      ev   = (e == 8'h80 && policy) ? 8'sd0 : $signed(e);
      r8   = 8'sd0;
      wide = {WIDE_W{1'b0}};
      sh   = 8'd0;
      if (scale == 8'hFF) begin
         decode_sat = {OUT_WIDTH{1'b0}};
      end else if (scale >= 8'd127) begin
         sh = scale - 8'd127;
         if (ev == 8'sd0) begin
            decode_sat = {OUT_WIDTH{1'b0}};
         end else if (sh >= SH_SAT) begin
            decode_sat = ev[7] ? OUT_MIN : OUT_MAX;
         end else begin
            wide = {{(WIDE_W-8){ev[7]}}, ev};
            wide = wide <<< sh;
            if (wide > WIDE_MAX)
               decode_sat = OUT_MAX;
            else if (wide < WIDE_MIN)
               decode_sat = OUT_MIN;
            else
               decode_sat = wide[OUT_WIDTH-1:0];
         end
      end else begin
         sh = 8'd127 - scale;
         if (sh >= 8'd8) begin
            decode_sat = ev[7] ? {OUT_WIDTH{1'b1}} : {OUT_WIDTH{1'b0}};
         end else begin
            r8 = ev >>> sh[2:0];
            decode_sat = {{(OUT_WIDTH-8){r8[7]}}, r8};
         end
      end
   endfunction

   assign w_stream = (r_state == STREAM);
   assign w_cur    = r_elems[r_index];
   assign w_value  = decode_sat(w_cur, r_scale, r_policy);

   // Element outputs depend only on the stored block and index, never on i_elem_ready.
   assign o_block_ready = r_block_ready;
   assign o_elem_valid  = w_stream;
   assign o_elem_value  = w_stream ? w_value : {OUT_WIDTH{1'b0}};
   assign o_elem_index  = w_stream ? r_index : {IDX_W{1'b0}};
   assign o_elem_last   = w_stream && (r_index == LAST_IDX);
   assign o_elem_nan    = w_stream && (r_scale == 8'hFF);

   always_ff @(posedge i_clk) begin
      if (i_rst) begin
         r_state       <= IDLE;
         r_index       <= {IDX_W{1'b0}};
         r_scale       <= 8'd0;
         r_policy      <= 1'b0;
         r_block_ready <= 1'b0;
         for (int i = 0; i < BLOCK_SIZE; i++)
            r_elems[i] <= 8'd0;
      end else begin
         case (r_state)
            IDLE: begin
               r_block_ready <= 1'b1;
               if (i_block_valid && r_block_ready) begin
                  for (int i = 0; i < BLOCK_SIZE; i++)
                     r_elems[i] <= i_mxint8_elements[i];
                  r_scale       <= i_shared_scale;
                  r_policy      <= i_treat_unused_encode_as_zero;
                  r_index       <= {IDX_W{1'b0}};
                  r_state       <= STREAM;
                  r_block_ready <= 1'b0;
               end
            end
            STREAM: begin
               if (i_elem_ready) begin
                  if (r_index == LAST_IDX) begin
                     r_state       <= IDLE;
                     r_index       <= {IDX_W{1'b0}};
                     r_block_ready <= 1'b1;
                  end else begin
                     r_index <= r_index + 1'b1;
                  end
               end
            end
            default: begin
               r_state       <= IDLE;
               r_block_ready <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_mxint8_block_unpacker.sv
// Randomized bench for mxint8_block_unpacker: a queue-based beat model built from
// the decode rules is compared against the DUT on every falling edge.
module tb_mxint8_block_unpacker;

   localparam int BS = 32;
   localparam int OW = 16;
   localparam int IW = $clog2(BS);

   logic           i_clk = 1'b0;
   logic           i_rst = 1'b1;
   logic           i_block_valid = 1'b0;
   logic           o_block_ready;
   logic [7:0]     elems [0:BS-1];
   logic [7:0]     i_shared_scale = 8'd0;
   logic           i_policy = 1'b0;
   logic           o_elem_valid;
   logic           i_elem_ready = 1'b0;
   logic [OW-1:0]  o_elem_value;
   logic [IW-1:0]  o_elem_index;
   logic           o_elem_last;
   logic           o_elem_nan;

   int n_checks = 0;
   int n_errors = 0;
   bit bp_mode  = 1'b0;

   typedef struct {
      int val;
      int idx;
      bit last;
      bit nan;
   } beat_t;
   beat_t q[$];
   bit    exp_ready = 1'b0;
   bit    started   = 1'b0;

   mxint8_block_unpacker #(.BLOCK_SIZE(BS), .OUT_WIDTH(OW)) dut (
      .i_clk                         (i_clk),
      .i_rst                         (i_rst),
      .i_block_valid                 (i_block_valid),
      .o_block_ready                 (o_block_ready),
      .i_mxint8_elements             (elems),
      .i_shared_scale                (i_shared_scale),
      .i_treat_unused_encode_as_zero (i_policy),
      .o_elem_valid                  (o_elem_valid),
      .i_elem_ready                  (i_elem_ready),
      .o_elem_value                  (o_elem_value),
      .o_elem_index                  (o_elem_index),
      .o_elem_last                   (o_elem_last),
      .o_elem_nan                    (o_elem_nan)
   );

   always #5 i_clk = ~i_clk;

   task automatic chk(input string nm, input logic signed [31:0] act, input logic signed [31:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_errors++;
         $display("FAIL %s: got %0d expected %0d at %0t", nm, act, exp, $time);
      end
   endtask

   task automatic timeout_fail(input string nm);
      n_checks++;
      n_errors++;
      $display("FAIL %s: timed out at %0t", nm, $time);
   endtask

   // Real value is e * 2^(scale-127) in units of 2^-6; floor for right shifts.
   function automatic int ref_val(input int e8, input int sc, input bit pol);
      longint e, v, p, mx, mn;
      int k, n;
      mx = (64'sd1 <<< (OW - 1)) - 1;
      mn = -(64'sd1 <<< (OW - 1));
      if (sc == 255) return 0;
      e = (e8 >= 128) ? e8 - 256 : e8;
      if (e == -128 && pol) e = 0;
      k = sc - 127;
      if (k >= 0) begin
         if (e == 0) return 0;
         if (k >= OW) return (e > 0) ? int'(mx) : int'(mn);
         v = e * (64'sd1 <<< k);
         if (v > mx) v = mx;
         if (v < mn) v = mn;
         return int'(v);
      end
      n = -k;
      if (n > 30) n = 30;
      p = 64'sd1 <<< n;
      if (e >= 0) v = e / p;
      else        v = -((-e + p - 1) / p);
      return int'(v);
   endfunction

   // Compare process and model update; model state after the coming rising edge.
   initial begin
      forever begin
         @(negedge i_clk);
         if (started) begin
            chk("block_ready", {31'd0, o_block_ready}, {31'd0, exp_ready});
            chk("elem_valid", {31'd0, o_elem_valid}, (q.size() != 0) ? 1 : 0);
            if (q.size() != 0) begin
               chk("elem_value", $signed(o_elem_value), q[0].val);
               chk("elem_index", {{(32-IW){1'b0}}, o_elem_index}, q[0].idx);
               chk("elem_last", {31'd0, o_elem_last}, {31'd0, q[0].last});
               chk("elem_nan", {31'd0, o_elem_nan}, {31'd0, q[0].nan});
            end else begin
               chk("idle_value", $signed(o_elem_value), 0);
               chk("idle_index", {{(32-IW){1'b0}}, o_elem_index}, 0);
               chk("idle_last", {31'd0, o_elem_last}, 0);
               chk("idle_nan", {31'd0, o_elem_nan}, 0);
            end
         end
         if (i_rst) begin
            started   = 1'b1;
            q.delete();
            exp_ready = 1'b0;
         end else if (started) begin
            bit acc;
            acc = exp_ready && i_block_valid;
            if (q.size() != 0 && i_elem_ready) void'(q.pop_front());
            if (acc) begin
               for (int i = 0; i < BS; i++)
                  q.push_back('{ref_val(int'(elems[i]), int'(i_shared_scale), i_policy),
                                i, (i == BS - 1), (i_shared_scale == 8'hFF)});
               exp_ready = 1'b0;
            end else begin
               exp_ready = (q.size() == 0);
            end
         end
      end
   end

   initial begin
      forever begin
         @(posedge i_clk);
         #1;
         i_elem_ready = bp_mode ? ($urandom_range(0, 1) == 1) : 1'b1;
      end
   end

   task automatic scramble_inputs();
      for (int i = 0; i < BS; i++) elems[i] = 8'($urandom);
      i_shared_scale = 8'($urandom);
      i_policy       = 1'($urandom);
   endtask

   task automatic send_block(input logic [7:0] sc, input bit pol);
      int  cnt;
      bit  acc;
      cnt = 0;
      i_shared_scale = sc;
      i_policy       = pol;
      i_block_valid  = 1'b1;
      forever begin
         acc = o_block_ready;
         @(posedge i_clk);
         #1;
         if (acc) break;
         cnt++;
         if (cnt > 3000) begin
            timeout_fail("block_accept");
            break;
         end
      end
      i_block_valid = 1'b0;
      scramble_inputs();
   endtask

   task automatic wait_idle();
      int cnt;
      cnt = 0;
      while (o_block_ready !== 1'b1) begin
         @(posedge i_clk);
         #1;
         cnt++;
         if (cnt > 5000) begin
            timeout_fail("wait_idle");
            break;
         end
      end
   endtask

   task automatic send_dir(input logic [7:0] sc, input logic [7:0] a, input logic [7:0] b, input bit pol);
      for (int i = 0; i < BS; i++) elems[i] = 8'($urandom);
      elems[0]    = a;
      elems[1]    = b;
      elems[BS-1] = a;
      send_block(sc, pol);
   endtask

   initial begin
      for (int i = 0; i < BS; i++) elems[i] = 8'd0;

      // Pin the model itself with hand-computed values.
      chk("pin_129_40", ref_val(8'h40, 129, 1'b0), 256);
      chk("pin_137_7F", ref_val(8'h7F, 137, 1'b0), 32767);
      chk("pin_137_81", ref_val(8'h81, 137, 1'b0), -32768);
      chk("pin_254_01", ref_val(8'h01, 254, 1'b0), 32767);
      chk("pin_254_00", ref_val(8'h00, 254, 1'b0), 0);
      chk("pin_125_C1", ref_val(8'hC1, 125, 1'b0), -16);
      chk("pin_125_3F", ref_val(8'h3F, 125, 1'b0), 15);
      chk("pin_0_7F",   ref_val(8'h7F, 0, 1'b0), 0);
      chk("pin_0_FF",   ref_val(8'hFF, 0, 1'b0), -1);
      chk("pin_80_p0",  ref_val(8'h80, 127, 1'b0), -128);
      chk("pin_80_p1",  ref_val(8'h80, 127, 1'b1), 0);
      chk("pin_nan",    ref_val(8'h55, 255, 1'b0), 0);

      i_rst = 1'b1;
      repeat (3) @(posedge i_clk);
      #1;
      i_rst = 1'b0;

      // Basic stream: elements[i] = i at unity scale.
      for (int i = 0; i < BS; i++) elems[i] = 8'(i);
      send_block(8'd127, 1'b0);
      wait_idle();

      // Directed decode corners, issued back to back.
      send_dir(8'd129, 8'h40, 8'h40, 1'b0);
      send_dir(8'd137, 8'h7F, 8'h81, 1'b0);
      send_dir(8'd254, 8'h01, 8'h00, 1'b0);
      send_dir(8'd125, 8'hC1, 8'h3F, 1'b0);
      send_dir(8'd0,   8'h7F, 8'hFF, 1'b0);
      send_dir(8'd127, 8'h80, 8'h80, 1'b0);
      send_dir(8'd127, 8'h80, 8'h80, 1'b1);
      send_dir(8'hFF,  8'h7F, 8'h80, 1'b0);
      wait_idle();

      // Random blocks under random backpressure.
      bp_mode = 1'b1;
      for (int b = 0; b < 12; b++) begin
         logic [7:0] sc;
         sc = ($urandom_range(0, 3) == 0) ? 8'($urandom) : 8'($urandom_range(110, 145));
         for (int i = 0; i < BS; i++) elems[i] = 8'($urandom);
         send_block(sc, 1'($urandom));
      end
      wait_idle();
      bp_mode = 1'b0;
      @(posedge i_clk);
      #1;

      // Reset after beat 10 while a new block is also being offered.
      for (int i = 0; i < BS; i++) elems[i] = 8'($urandom);
      send_block(8'd130, 1'b0);
      repeat (11) @(posedge i_clk);
      #1;
      i_rst         = 1'b1;
      i_block_valid = 1'b1;
      @(posedge i_clk);
      #1;
      i_rst         = 1'b0;
      i_block_valid = 1'b0;
      for (int i = 0; i < BS; i++) elems[i] = 8'($urandom);
      send_block(8'd120, 1'b1);
      wait_idle();

      repeat (3) @(posedge i_clk);
      #1;
      $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
      $finish;
   end

endmodule
